// File: rtl/gb_dbg_pkg.sv
// rtl/gb_dbg_pkg.sv - shared opcodes, state encoding and sizing helper for the run controller
package gb_dbg_pkg;

    localparam logic [2:0] OP_NOP      = 3'd0;
    localparam logic [2:0] OP_HALT     = 3'd1;
    localparam logic [2:0] OP_RUN      = 3'd2;
    localparam logic [2:0] OP_STEP     = 3'd3;
    localparam logic [2:0] OP_SET_BP   = 3'd4;
    localparam logic [2:0] OP_CLR_BP   = 3'd5;
    localparam logic [2:0] OP_CORE_RST = 3'd6;

    typedef enum logic [2:0] {
        S_WAIT,
        S_RESET,
        S_RUN,
        S_HALT,
        S_STEP
    } run_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/gb_bp_match.sv
// rtl/gb_bp_match.sv - address breakpoint slots with per-slot comparators
module gb_bp_match #(
    parameter int BP_COUNT = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic                wr_set,
    input  logic [2:0]          wr_idx,
    input  logic [15:0]         wr_addr,
    input  logic                probe,
    input  logic [15:0]         addr,
    output logic [BP_COUNT-1:0] match
);

    logic [BP_COUNT-1:0] slot_en;
    logic [15:0]         slot_addr [BP_COUNT];

    // Indices at or above BP_COUNT never hit a slot, so out-of-range writes drop silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_en <= '0;
            for (int i = 0; i < BP_COUNT; i++) begin
                slot_addr[i] <= '0;
            end
        end else if (wr_en) begin
            for (int i = 0; i < BP_COUNT; i++) begin
                if (wr_idx == 3'(i)) begin
                    slot_en[i] <= wr_set;
                    if (wr_set) begin
                        slot_addr[i] <= wr_addr;
                    end
                end
            end
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < BP_COUNT; i++) begin
            match[i] = probe && slot_en[i] && (addr == slot_addr[i]);
        end
    end

endmodule

// File: rtl/gb_run_ctrl.sv
// rtl/gb_run_ctrl.sv - core reset sequencing, clock-enable divider and debug halt/run/step
module gb_run_ctrl
    import gb_dbg_pkg::*;
#(
    parameter int RST_WAIT = 3840,
    parameter int RST_HOLD = 255,
    parameter int CE_DIV   = 64,
    parameter int BP_COUNT = 2,
    parameter int STEP_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [2:0]          cmd_idx,
    input  logic [15:0]         cmd_arg,
    input  logic [15:0]         core_addr,
    input  logic                core_rd,
    output logic                core_ce,
    output logic                core_rst,
    output logic                halted,
    output logic [BP_COUNT-1:0] bp_hit
);

    localparam int CW = $clog2(max3(RST_WAIT, RST_HOLD, CE_DIV) + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(RST_WAIT - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
    localparam logic [CW-1:0] DIV_LAST  = CW'(CE_DIV - 1);

    run_state_t          state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [CW-1:0]       div, div_nxt;
    logic [STEP_W-1:0]   step_left, step_nxt;
    logic [BP_COUNT-1:0] bp_hit_nxt;
    logic [BP_COUNT-1:0] match;
    logic [STEP_W-1:0]   step_arg;
    logic                accept;
    logic                active;
    logic                bp_any;
    logic                clr_hit;

    assign accept    = cmd_valid && cmd_ready;
    assign active    = (state == S_RUN) || (state == S_STEP);
    assign cmd_ready = (state == S_RUN) || (state == S_HALT) || (state == S_STEP);
    assign core_ce   = active && (div == DIV_LAST);
    assign core_rst  = (state == S_RESET);
    assign halted    = (state == S_HALT);
    assign bp_any    = |match;
    assign step_arg  = cmd_arg[STEP_W-1:0];

    gb_bp_match #(
        .BP_COUNT(BP_COUNT)
    ) u_bp_match (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (accept && ((cmd_op == OP_SET_BP) || (cmd_op == OP_CLR_BP))),
        .wr_set  (cmd_op == OP_SET_BP),
        .wr_idx  (cmd_idx),
        .wr_addr (cmd_arg),
        .probe   (core_ce && core_rd),
        .addr    (core_addr),
        .match   (match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_WAIT;
            cnt       <= '0;
            div       <= '0;
            step_left <= '0;
            bp_hit    <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div       <= div_nxt;
            step_left <= step_nxt;
            bp_hit    <= bp_hit_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div_nxt   = div;
        step_nxt  = step_left;
        clr_hit   = 1'b0;
        unique case (state)
            S_WAIT: begin
                div_nxt = '0;
                if (cnt == WAIT_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_RESET;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RESET: begin
                div_nxt = '0;
                if (cnt == HOLD_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = S_RUN;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RUN: begin
                div_nxt = core_ce ? '0 : div + 1'b1;
                if (accept && (cmd_op == OP_RUN)) begin
                    clr_hit = 1'b1;
                end
                if (bp_any || (accept && (cmd_op == OP_HALT))) begin
                    state_nxt = S_HALT;
                end
            end
            S_HALT: begin
                // Divider is frozen here so the pulse period is unbroken across a halt.
                if (accept && (cmd_op == OP_RUN)) begin
                    clr_hit   = 1'b1;
                    state_nxt = S_RUN;
                end else if (accept && (cmd_op == OP_STEP)) begin
                    clr_hit   = 1'b1;
                    step_nxt  = (step_arg == '0) ? STEP_W'(1) : step_arg;
                    state_nxt = S_STEP;
                end
            end
            S_STEP: begin
                div_nxt = core_ce ? '0 : div + 1'b1;
                if (core_ce) begin
                    step_nxt = step_left - 1'b1;
                end
                if (bp_any || (accept && (cmd_op == OP_HALT)) ||
                    (core_ce && (step_left == STEP_W'(1)))) begin
                    state_nxt = S_HALT;
                end
            end
            default: state_nxt = S_WAIT;
        endcase
        // Commands are only accepted past S_WAIT, so this restart covers every legal source.
        if (accept && (cmd_op == OP_CORE_RST)) begin
            state_nxt = S_RESET;
            cnt_nxt   = '0;
            div_nxt   = '0;
        end
        bp_hit_nxt = (clr_hit ? '0 : bp_hit) | match;
    end

endmodule

// File: tb/tb_gb_run_ctrl.sv
// tb/tb_gb_run_ctrl.sv - scoreboard bench for gb_run_ctrl sequencing, stepping and breakpoints
module tb_gb_run_ctrl;
    import gb_dbg_pkg::*;

    localparam int W   = 20;
    localparam int H   = 5;
    localparam int D   = 4;
    localparam int BPN = 2;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cmd_valid = 1'b0;
    logic [2:0]     cmd_op = 3'd0;
    logic [2:0]     cmd_idx = 3'd0;
    logic [15:0]    cmd_arg = 16'd0;
    logic [15:0]    core_addr = 16'd0;
    logic           core_rd = 1'b0;
    logic           cmd_ready, core_ce, core_rst, halted;
    logic [BPN-1:0] bp_hit;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;
    int exp_q[$];

    gb_run_ctrl #(
        .RST_WAIT (W),
        .RST_HOLD (H),
        .CE_DIV   (D),
        .BP_COUNT (BPN),
        .STEP_W   (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_idx   (cmd_idx),
        .cmd_arg   (cmd_arg),
        .core_addr (core_addr),
        .core_rd   (core_rd),
        .core_ce   (core_ce),
        .core_rst  (core_rst),
        .halted    (halted),
        .bp_hit    (bp_hit)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Every core_ce pulse seen while monitoring must match the next expected cycle.
    always @(negedge clk) begin
        if (mon_en && core_ce === 1'b1) begin
            if (exp_q.size() == 0) check("ce_unexpected", 32'(core_ce), 32'd0);
            else check("ce_cycle", cyc, exp_q.pop_front());
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [2:0] op, input logic [2:0] idx, input logic [15:0] arg);
        check("cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_idx   = idx;
        cmd_arg   = arg;
        tick;
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    task automatic wait_ce(input int budget);
        int n;
        n = 0;
        while (core_ce !== 1'b1 && n < budget) begin
            tick;
            n++;
        end
        check("ce_wait", 32'(core_ce), 32'd1);
    endtask

    task automatic quiet(input int n);
        mon_en = 1'b1;
        repeat (n) tick;
        check("sb_drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        int r0, first_hi, n_hi, c;
        repeat (2) tick;
        rst = 1'b0;

        r0 = cyc;
        first_hi = -1;
        n_hi = 0;
        check("rst_ready", 32'(cmd_ready), 32'd0);
        check("rst_ce", 32'(core_ce), 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_bp_hit", 32'(bp_hit), 32'd0);
        for (int j = 0; j < 3; j++) exp_q.push_back(r0 + W + H + D - 1 + j * D);
        mon_en = 1'b1;
        for (int k = 0; k < W + H + 3 * D; k++) begin
            if (core_rst) begin
                if (first_hi < 0) first_hi = k;
                n_hi++;
            end
            tick;
        end
        mon_en = 1'b0;
        check("pwr_sb_drain", exp_q.size(), 32'd0);
        check("pwr_rst_first", first_hi, W);
        check("pwr_rst_len", n_hi, H);

        wait_ce(2 * D);
        send(OP_HALT, 3'd0, 16'd0);
        check("halt", 32'(halted), 32'd1);
        mon_en = 1'b1;
        send(OP_HALT, 3'd0, 16'd0);
        check("halt_noop", 32'(halted), 32'd1);
        quiet(2 * D);

        c = cyc;
        for (int j = 1; j <= 3; j++) exp_q.push_back(c + j * D);
        send(OP_STEP, 3'd0, 16'd3);
        repeat (3 * D - 1) tick;
        check("step3_before_end", 32'(halted), 32'd0);
        tick;
        check("step3_halted", 32'(halted), 32'd1);
        quiet(2 * D);

        c = cyc;
        exp_q.push_back(c + D);
        send(OP_STEP, 3'd0, 16'd0);
        repeat (D - 1) tick;
        check("step0_before_end", 32'(halted), 32'd0);
        tick;
        check("step0_halted", 32'(halted), 32'd1);
        quiet(2 * D);

        send(OP_SET_BP, 3'd0, 16'h0150);
        send(OP_SET_BP, 3'd5, 16'h0200);
        c = cyc;
        exp_q.push_back(c + D);
        exp_q.push_back(c + 2 * D);
        send(OP_RUN, 3'd0, 16'd0);
        repeat (2 * D - 1) tick;
        core_rd = 1'b1;
        core_addr = 16'h0150;
        check("bp_ce", 32'(core_ce), 32'd1);
        tick;
        core_rd = 1'b0;
        check("bp_halted", 32'(halted), 32'd1);
        check("bp_hit_slot0", 32'(bp_hit), 32'd1);
        quiet(2 * D);

        c = cyc;
        exp_q.push_back(c + D);
        exp_q.push_back(c + 2 * D);
        send(OP_RUN, 3'd0, 16'd0);
        check("run_clears_hit", 32'(bp_hit), 32'd0);
        check("run_resumed", 32'(halted), 32'd0);
        repeat (D - 1) tick;
        core_rd = 1'b1;
        core_addr = 16'h0200;
        tick;
        core_rd = 1'b0;
        check("bad_idx_ignored", 32'(halted), 32'd0);
        repeat (D - 1) tick;
        core_rd = 1'b1;
        core_addr = 16'h0150;
        send(OP_RUN, 3'd0, 16'd0);
        core_rd = 1'b0;
        check("bp_beats_run", 32'(halted), 32'd1);
        check("bp_beats_run_hit", 32'(bp_hit), 32'd1);
        quiet(2 * D);

        c = cyc;
        exp_q.push_back(c + D);
        exp_q.push_back(c + 2 * D);
        send(OP_STEP, 3'd0, 16'd5);
        check("step_clears_hit", 32'(bp_hit), 32'd0);
        repeat (2 * D - 1) tick;
        check("step5_ce2", 32'(core_ce), 32'd1);
        send(OP_HALT, 3'd0, 16'd0);
        check("step5_halt_abort", 32'(halted), 32'd1);
        quiet(3 * D);

        c = cyc;
        send(OP_RUN, 3'd0, 16'd0);
        exp_q.push_back(c + H + D + 1);
        send(OP_CORE_RST, 3'd0, 16'd0);
        first_hi = -1;
        n_hi = 0;
        check("corerst_not_ready", 32'(cmd_ready), 32'd0);
        for (int k = 0; k < H + 2; k++) begin
            if (core_rst) begin
                if (first_hi < 0) first_hi = k;
                n_hi++;
            end
            tick;
        end
        check("corerst_first", first_hi, 32'd0);
        check("corerst_len", n_hi, H);
        while (cyc < c + H + D + 1) tick;
        core_rd = 1'b1;
        core_addr = 16'h0150;
        check("corerst_ce", 32'(core_ce), 32'd1);
        tick;
        core_rd = 1'b0;
        check("corerst_bp_kept", 32'(halted), 32'd1);
        check("corerst_bp_hit", 32'(bp_hit), 32'd1);
        quiet(2 * D);

        c = cyc;
        exp_q.push_back(c + D);
        send(OP_STEP, 3'd0, 16'd5);
        repeat (D + 1) tick;
        rst = 1'b1;
        tick;
        mon_en = 1'b0;
        check("midrst_sb_drain", exp_q.size(), 32'd0);
        check("midrst_ready", 32'(cmd_ready), 32'd0);
        check("midrst_ce", 32'(core_ce), 32'd0);
        check("midrst_core_rst", 32'(core_rst), 32'd0);
        check("midrst_halted", 32'(halted), 32'd0);
        check("midrst_bp_hit", 32'(bp_hit), 32'd0);
        rst = 1'b0;
        core_rd = 1'b1;
        core_addr = 16'h0150;
        repeat (W + H + 3 * D) tick;
        check("midrst_bp_cleared", 32'(halted), 32'd0);
        check("midrst_no_hit", 32'(bp_hit), 32'd0);
        core_rd = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
